jt053260_dacser: RTL and testbench
==================================

JT053260_DACSER -- requirements
Module: jt053260_dacser

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 cen  in  1  clock enable; the serial timebase advances only on cycles with cen=1.
REQ-004 snd_l  in  16  signed left mix from the 053260 channel mixer.
REQ-005 snd_r  in  16  signed right mix from the 053260 channel mixer.
REQ-006 sample  out  1  one-clk pulse on the cen cycle that captures snd_l/snd_r; the upstream mixer treats it as a sample request.
REQ-007 so  out  1  serial data to YM3012, LSB first.
REQ-008 sy  out  1  serial bit clock to YM3012.
REQ-009 sh1  out  1  left-channel latch strobe.
REQ-010 sh2  out  1  right-channel latch strobe.

Function
REQ-011 Phase counter cnt[5:0] shall increment by 1 on each cen, wrapping 63->0; a frame is 64 cen ticks.
REQ-012 sy shall equal cnt[0], registered.
REQ-013 Bit index shall be cnt[5:1]: 0-15 = left word, 16-31 = right word.
REQ-014 On the cen where cnt goes 63->0: snd_l and snd_r shall be encoded and loaded into word registers wl and wr; sample shall be high on that clk only.
REQ-015 Encoding: exponent e = smallest value in 1..7 such that (x >>> (e-1)) fits in a 10-bit signed range (-512..511); mantissa m = (x >>> (e-1))[9:0] with bit 9 inverted (offset binary).
REQ-016 Word format: bits 2:0 = 0; bits 12:3 = m; bits 15:13 = e.
REQ-017 -32768 shall encode to e=7, m=0x000; no saturation logic is needed because every 16-bit input fits at e=7.
REQ-018 so shall update only on cen ticks where cnt becomes even (sy falling): so = wl[bit] for bits 0-15, wr[bit-16] for bits 16-31.
REQ-019 sh1 shall be 1 throughout bit index 15 (cnt 30,31) and 0 otherwise; its falling edge, at cnt 31->32, latches left.
REQ-020 sh2 shall be 1 throughout bit index 31 (cnt 62,63) and 0 otherwise; its falling edge, at cnt 63->0, latches right.
REQ-021 Input changes between capture points shall not affect the frame in flight; wl/wr are held for the full 64 ticks.
REQ-022 With cen held low, all outputs and state shall hold, and sample shall stay 0.
REQ-023 Latency: a sample captured at frame start shall be fully shifted out and latched by the end of that same frame (64 cen ticks).

Reset
REQ-024 While rst_n=0: cnt=0, wl=wr=0, so=0, sy=0, sh1=0, sh2=0, sample=0.
REQ-025 Reset asserted mid-frame shall abort the frame immediately.
REQ-026 After reset release, the first capture shall occur on the 64th cen (cnt 63->0), so the first frame after reset shifts out all-zero words.

Structure
REQ-027 The frame constants (frame length 64, word length 16, sh1 and sh2 bit indices) shall be placed in a shared package jt053260_pkg.
REQ-028 The float encoder shall be a combinational sub-module, jt053260_dacfloat: input 16-bit signed; outputs e[2:0] and m[9:0]. It shall be instantiated twice, once for left and once for right.
REQ-029 Target RTL size is 120-400 lines, including the sub-module.

Verification
REQ-030 snd_l=0x0000 -> wl=0x3000 (e=1, m=0x200); so bits 12 and 13 = 1 on left slot, all other left bits 0.
REQ-031 snd_l=0x7FFF -> 0xFFF8; snd_r=0x8000 -> 0xE000; snd_l=0x01FF -> 0x3FF8; snd_l=0x0200 -> 0x5800 (e=2 boundary).
REQ-032 Run 3 frames at cen every 4th clk -> sample pulses exactly every 256 clk; sh1 high only at cnt 30-31 and sh2 high only at cnt 62-63; so stable while sy=1.
REQ-033 Change snd_l at cnt=20 -> the current frame still carries the old word, and the next frame carries the new word.
REQ-034 Assert rst_n=0 at cnt=40 for 3 clk -> all outputs 0 immediately; after release, sample first pulses on the 64th cen.
REQ-035 Hold cen=0 for 100 clk mid-frame -> no output toggles and no sample pulse; the sequence resumes at the same cnt value.

Source files
------------

// File: rtl/jt053260_pkg.sv
// ============================================================================
// jt053260_pkg : frame constants and word packing shared by the 053260 DAC serialiser
// Rev 1.0
// ============================================================================
`default_nettype none

package jt053260_pkg;

  localparam int FRAME_LEN = 64;
  localparam int WORD_LEN  = 16;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int BIT_W     = CNT_W - 1;
  localparam int SH1_BIT   = WORD_LEN - 1;
  localparam int SH2_BIT   = 2 * WORD_LEN - 1;
  localparam int E_W       = 3;
  localparam int M_W       = 10;
  localparam int MAX_SHIFT = 6;

  // YM3012 word: exponent on top, offset-binary mantissa, three zero pad bits
  function automatic logic [WORD_LEN-1:0] pack_word(input logic [E_W-1:0] e,
                                                    input logic [M_W-1:0] m);
    return {e, m, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt053260_dacser_if.sv
// ============================================================================
// jt053260_dacser_if : mixer-side inputs and YM3012-side serial outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface jt053260_dacser_if;

  logic signed [15:0] snd_l;
  logic signed [15:0] snd_r;
  logic               sample;
  logic               so;
  logic               sy;
  logic               sh1;
  logic               sh2;

  modport master (
    input  snd_l, snd_r,
    output sample, so, sy, sh1, sh2
  );

  modport slave (
    output snd_l, snd_r,
    input  sample, so, sy, sh1, sh2
  );

endinterface

`default_nettype wire

// File: rtl/jt053260_dacfloat.sv
// ============================================================================
// jt053260_dacfloat : combinational 16-bit linear to YM3012 3.10 float encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module jt053260_dacfloat
  import jt053260_pkg::*;
(
  input  logic signed [15:0] x,
  output logic [E_W-1:0]     e,
  output logic [M_W-1:0]     m
);

  logic signed [15:0] sh;

  // Scan from the coarsest shift down so the last fit found is the smallest exponent
  always_comb begin
    e  = E_W'(MAX_SHIFT + 1);
    m  = '0;
    sh = x;
    for (int k = MAX_SHIFT; k >= 0; k--) begin
      sh = x >>> k;
      if (sh[15:9] == {7{sh[9]}}) begin
        e = E_W'(k + 1);
        m = {~sh[9], sh[8:0]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jt053260_dacser.sv
// ============================================================================
// jt053260_dacser : 64-tick frame serialiser feeding a YM3012 DAC from the 053260 mixer
// Rev 1.0
// ============================================================================
`default_nettype none

module jt053260_dacser
  import jt053260_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jt053260_dacser_if.master bus
);

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [BIT_W-1:0]    bit_nxt;
  logic [WORD_LEN-1:0] wl;
  logic [WORD_LEN-1:0] wr;
  logic [WORD_LEN-1:0] enc_l;
  logic [WORD_LEN-1:0] enc_r;
  logic [WORD_LEN-1:0] wl_src;
  logic [WORD_LEN-1:0] wr_src;
  logic [E_W-1:0]      e_l;
  logic [E_W-1:0]      e_r;
  logic [M_W-1:0]      m_l;
  logic [M_W-1:0]      m_r;
  logic                wrap;
  logic                so_nxt;

  jt053260_dacfloat u_float_l (.x(bus.snd_l), .e(e_l), .m(m_l));
  jt053260_dacfloat u_float_r (.x(bus.snd_r), .e(e_r), .m(m_r));

  assign enc_l      = pack_word(e_l, m_l);
  assign enc_r      = pack_word(e_r, m_r);
  assign cnt_nxt    = cnt + 1'b1;
  assign bit_nxt    = cnt_nxt[CNT_W-1:1];
  assign wrap       = (cnt == CNT_W'(FRAME_LEN - 1));
  assign bus.sample = cen & wrap;

  // Bit 0 of a new frame leaves on the capture tick, so it must come from the fresh word
  assign wl_src = wrap ? enc_l : wl;
  assign wr_src = wrap ? enc_r : wr;
  assign so_nxt = bit_nxt[BIT_W-1] ? wr_src[bit_nxt[BIT_W-2:0]]
                                   : wl_src[bit_nxt[BIT_W-2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      wl      <= '0;
      wr      <= '0;
      bus.so  <= 1'b0;
      bus.sy  <= 1'b0;
      bus.sh1 <= 1'b0;
      bus.sh2 <= 1'b0;
    end else if (cen) begin
      cnt     <= cnt_nxt;
      bus.sy  <= cnt_nxt[0];
      bus.sh1 <= (bit_nxt == BIT_W'(SH1_BIT));
      bus.sh2 <= (bit_nxt == BIT_W'(SH2_BIT));
      if (wrap) begin
        wl <= enc_l;
        wr <= enc_r;
      end
      if (!cnt_nxt[0]) begin
        bus.so <= so_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jt053260_dacser.sv
// ============================================================================
// tb_jt053260_dacser : directed frames with hand-computed YM3012 words
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jt053260_dacser;

  logic clk;
  logic rst_n;
  logic cen;

  jt053260_dacser_if bus ();

  jt053260_dacser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   mcnt     = 0;
  int   seq_err  = 0;
  int   hold_err = 0;
  int   n_smp    = 0;
  int   s0;
  logic last_so  = 1'b0;
  time  last_t   = 0;
  time  gap      = 0;
  logic [15:0] lw, rw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sample === 1'b1) begin
      if (last_t != 0) gap = $time - last_t;
      last_t = $time;
      n_smp++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cen pulse, then three idle clocks: cen every 4th clk
  task automatic tick();
    @(negedge clk);
    cen = 1'b1;
    @(posedge clk);
    #1;
    cen  = 1'b0;
    mcnt = (mcnt + 1) % 64;
    if (bus.sy  !== ((mcnt % 2) == 1))  seq_err++;
    if (bus.sh1 !== ((mcnt / 2) == 15)) seq_err++;
    if (bus.sh2 !== ((mcnt / 2) == 31)) seq_err++;
    if ((mcnt % 2) == 1) begin
      if (bus.so !== last_so) seq_err++;
    end else begin
      last_so = bus.so;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic hold();
    logic [4:0] snap;
    snap = {bus.so, bus.sy, bus.sh1, bus.sh2, 1'b0};
    repeat (100) begin
      @(negedge clk);
      if ({bus.so, bus.sy, bus.sh1, bus.sh2, bus.sample} !== snap) hold_err++;
    end
  endtask

  task automatic run_ticks(input int n, input int chg_at, input logic [15:0] chg_val,
                           input int pause_at, output logic [15:0] l, output logic [15:0] r);
    int b;
    l = '0;
    r = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      if ((mcnt % 2) == 0) begin
        b = mcnt / 2;
        if (b < 16) l[b] = bus.so;
        else        r[b-16] = bus.so;
      end
      if (mcnt == chg_at)   bus.snd_l = chg_val;
      if (mcnt == pause_at) hold();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cen       = 1'b0;
    bus.snd_l = 16'sh0000;
    bus.snd_r = 16'sh0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {27'd0, bus.so, bus.sy, bus.sh1, bus.sh2, bus.sample}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First frame after reset carries zero words and no capture
    bus.snd_l = 16'sh0000;
    bus.snd_r = 16'sh8000;
    s0 = n_smp;
    run_ticks(63, -1, 16'h0, -1, lw, rw);
    check("prime_l",   lw, 32'h0000);
    check("prime_r",   rw, 32'h0000);
    check("prime_smp", n_smp - s0, 32'd0);

    s0 = n_smp;
    run_ticks(64, -1, 16'h0, -1, lw, rw);
    check("A_l",   lw, 32'h3000);
    check("A_r",   rw, 32'hE000);
    check("A_smp", n_smp - s0, 32'd1);

    bus.snd_l = 16'sh7FFF;
    bus.snd_r = 16'sh01FF;
    run_ticks(64, -1, 16'h0, -1, lw, rw);
    check("B_l", lw, 32'hFFF8);
    check("B_r", rw, 32'h3FF8);

    bus.snd_l = 16'sh0200;
    bus.snd_r = 16'sh7FFF;
    run_ticks(64, -1, 16'h0, -1, lw, rw);
    check("C_l",     lw, 32'h5800);
    check("C_r",     rw, 32'hFFF8);
    check("smp_gap", 32'(gap), 32'd2560);
    check("seq_ABC", seq_err, 32'd0);

    // Input change mid-frame must wait for the next capture
    bus.snd_l = 16'shFFFF;
    bus.snd_r = 16'shC000;
    run_ticks(64, 20, 16'h0200, -1, lw, rw);
    check("D_l", lw, 32'h2FF8);
    check("D_r", rw, 32'hC000);

    bus.snd_r = 16'sh0400;
    run_ticks(64, -1, 16'h0, -1, lw, rw);
    check("E_l", lw, 32'h5800);
    check("E_r", rw, 32'h7800);

    // cen held low for 100 clk mid-frame
    bus.snd_l = 16'shFE00;
    bus.snd_r = 16'sh01FF;
    s0 = n_smp;
    run_ticks(64, -1, 16'h0, 21, lw, rw);
    check("F_l",    lw, 32'h2000);
    check("F_r",    rw, 32'h3FF8);
    check("F_hold", hold_err, 32'd0);
    check("F_smp",  n_smp - s0, 32'd1);
    check("seq_DF", seq_err, 32'd0);

    // Reset at cnt=40 aborts the frame at once
    bus.snd_l = 16'sh7FFF;
    bus.snd_r = 16'sh8000;
    run_ticks(41, -1, 16'h0, -1, lw, rw);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {27'd0, bus.so, bus.sy, bus.sh1, bus.sh2, bus.sample}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_hold", {27'd0, bus.so, bus.sy, bus.sh1, bus.sh2, bus.sample}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    mcnt    = 0;
    last_so = 1'b0;

    s0 = n_smp;
    run_ticks(63, -1, 16'h0, -1, lw, rw);
    check("prime2_l",   lw, 32'h0000);
    check("prime2_r",   rw, 32'h0000);
    check("prime2_smp", n_smp - s0, 32'd0);

    s0 = n_smp;
    run_ticks(64, -1, 16'h0, -1, lw, rw);
    check("G_smp", n_smp - s0, 32'd1);
    check("G_l",   lw, 32'hFFF8);
    check("G_r",   rw, 32'hE000);
    check("seq_all", seq_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
